// File: rtl/cursor_pkg.sv
// Shared types and constants for the cursor position controller.
// Optional build macro CURSOR_FRAME_SYNC_EN is used by cursor_position_ctrl.
package cursor_pkg;

    localparam int COORD_W  = 11;
    localparam int DELTA_W  = 9;
    localparam int SUM_W    = 13;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        CLAMP,
        EMIT
    } state_t;

endpackage

// File: rtl/cursor_axis_acc.sv
// One axis of the cursor accumulator: sign-extend, scale, add or subtract,
// then clamp to 0..LIMIT-1.
module cursor_axis_acc
    import cursor_pkg::*;
#(
    parameter int LIMIT  = SCREEN_W,
    parameter bit INVERT = 1'b0,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sum_en,
    input  logic [COORD_W-1:0]        pos,
    input  logic signed [DELTA_W-1:0] delta,
    output logic [COORD_W-1:0]        clamped
);

    localparam logic signed [SUM_W-1:0] MAX_POS = SUM_W'(LIMIT - 1);

    logic signed [SUM_W-1:0] delta_ext;
    logic signed [SUM_W-1:0] pos_ext;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;

    assign delta_ext = {{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta} <<< SHIFT;
    assign pos_ext   = {{(SUM_W-COORD_W){1'b0}}, pos};

    // Screen Y grows downward, so the Y axis subtracts the delta.
    assign sum_d = INVERT ? (pos_ext - delta_ext) : (pos_ext + delta_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (sum_en) begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        clamped = sum_q[COORD_W-1:0];
        if (sum_q[SUM_W-1]) begin
            clamped = '0;
        end else if (sum_q > MAX_POS) begin
            clamped = COORD_W'(LIMIT - 1);
        end
    end

endmodule

// File: rtl/cursor_position_ctrl.sv
// Accumulates PS/2 relative motion into a clamped absolute cursor position.
// Define CURSOR_FRAME_SYNC_EN to update the visible cursor only on frame_start.
module cursor_position_ctrl
    import cursor_pkg::*;
#(
    parameter int H           = SCREEN_H,
    parameter int W           = SCREEN_W,
    parameter int SCALE_SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [DELTA_W-1:0] dx,
    input  logic [DELTA_W-1:0] dy,
    input  logic               btn_left,
    input  logic               frame_start,
    output logic [COORD_W-1:0] cursorX,
    output logic [COORD_W-1:0] cursorY,
    output logic               draw_req,
    output logic [COORD_W-1:0] draw_x,
    output logic [COORD_W-1:0] draw_y
);

    localparam logic [COORD_W-1:0] HOME_X = COORD_W'(W / 2);
    localparam logic [COORD_W-1:0] HOME_Y = COORD_W'(H / 2);

    state_t state_q;
    state_t state_d;

    logic signed [DELTA_W-1:0] dx_q;
    logic signed [DELTA_W-1:0] dy_q;
    logic                      btn_q;
    logic [COORD_W-1:0]        pend_x;
    logic [COORD_W-1:0]        pend_y;
    logic [COORD_W-1:0]        clamp_x;
    logic [COORD_W-1:0]        clamp_y;
    logic                      accept;
    logic                      load_vis;

    assign move_ready = (state_q == IDLE);
    assign accept     = move_valid & move_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SUM;
            SUM:     state_d = CLAMP;
            CLAMP:   state_d = EMIT;
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            btn_q    <= 1'b0;
            pend_x   <= HOME_X;
            pend_y   <= HOME_Y;
            draw_req <= 1'b0;
            draw_x   <= '0;
            draw_y   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dx_q  <= dx;
                dy_q  <= dy;
                btn_q <= btn_left;
            end
            if (state_q == CLAMP) begin
                pend_x <= clamp_x;
                pend_y <= clamp_y;
            end
            // draw_req is high for exactly the EMIT cycle.
            draw_req <= (state_q == CLAMP) && btn_q;
            if ((state_q == CLAMP) && btn_q) begin
                draw_x <= clamp_x;
                draw_y <= clamp_y;
            end
        end
    end

`ifdef CURSOR_FRAME_SYNC_EN
    assign load_vis = frame_start;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign load_vis = (state_q == EMIT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cursorX <= HOME_X;
            cursorY <= HOME_Y;
        end else if (load_vis) begin
            cursorX <= pend_x;
            cursorY <= pend_y;
        end
    end

    cursor_axis_acc #(
        .LIMIT  (W),
        .INVERT (1'b0),
        .SHIFT  (SCALE_SHIFT)
    ) u_acc_x (
        .clk     (clk),
        .reset   (reset),
        .sum_en  (state_q == SUM),
        .pos     (pend_x),
        .delta   (dx_q),
        .clamped (clamp_x)
    );

    cursor_axis_acc #(
        .LIMIT  (H),
        .INVERT (1'b1),
        .SHIFT  (SCALE_SHIFT)
    ) u_acc_y (
        .clk     (clk),
        .reset   (reset),
        .sum_en  (state_q == SUM),
        .pos     (pend_y),
        .delta   (dy_q),
        .clamped (clamp_y)
    );

endmodule

// File: doc/cursor_position_ctrl.md
Name: cursor_position_ctrl

Overview:
- Produces the cursorX/cursorY coordinates consumed by the VGA cursor overlay.
- Accepts relative-motion packets from the PS/2 mouse decoder: 9-bit two's-complement dx/dy plus left button.
- Accumulates the packets into an absolute position, clamped to the W x H drawing area.
- Emits a one-cycle draw request to the frame-buffer writer while the left button is held.

Parameters:
- H, 480, drawing-area height in pixels; legal Y is 0..H-1.
- W, 640, drawing-area width in pixels; legal X is 0..W-1.
- SCALE_SHIFT, 0, left-shift applied to dx/dy before accumulation (0..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  motion packet present.
- move_ready  out  1  block can accept a packet.
- dx  in  9  signed X delta; positive means right.
- dy  in  9  signed Y delta; positive means up (PS/2 convention).
- btn_left  in  1  left-button state sampled with the packet.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- cursorX  out  11  visible cursor X.
- cursorY  out  11  visible cursor Y.
- draw_req  out  1  one-cycle pulse requesting a pixel write.
- draw_x  out  11  write X, valid with draw_req.
- draw_y  out  11  write Y, valid with draw_req.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. It is sampled only on the rising clk edge, overrides everything else, and may assert in any state.
- Reset values:
  - State goes to IDLE; move_ready=1.
  - Pending and visible positions go to (W/2, H/2), i.e. (320,240) with defaults.
  - draw_req=0; draw_x=draw_y=0.
- Handshake: a packet is accepted on a cycle where move_valid & move_ready. dx, dy and btn_left are latched on that cycle. move_ready is 1 only in IDLE.
- State machine: IDLE -> SUM -> CLAMP -> EMIT -> IDLE. There is one cycle per state, so the next packet can be accepted 4 cycles after the previous accept.
  - IDLE: wait for accept; latch inputs.
  - SUM:
    - Sign-extend the delta to 13 bits and shift left by SCALE_SHIFT.
    - sx = posX + dx; sy = posY - dy. The Y axis is inverted because screen Y grows downward.
    - All arithmetic is 13-bit signed, so no overflow occurs.
  - CLAMP:
    - sx<0 -> 0; sx>W-1 -> W-1; same rule for Y against H-1.
    - Write the result to the pending position.
  - EMIT:
    - If latched btn_left=1, pulse draw_req for this cycle, with draw_x/draw_y = the new pending position.
    - A pulse is issued even if the position did not change (a click paints one pixel).
- Visible update: cursorX/cursorY follow the pending position, either at the next frame_start or one cycle after CLAMP (see Optional Feature).
- Boundaries:
  - Position exactly 0 or W-1 / H-1 is legal.
  - dx=-256 at X=0 stays 0; dx=+255 at X=W-1 stays W-1.
  - A zero delta with btn=0 produces no observable change except the handshake.
- Simultaneous events:
  - frame_start in the same cycle as the CLAMP write commits the pre-write pending value. The new value commits at the following frame_start.
  - move_valid held high while not ready: the packet is held by the producer and is not dropped.
- Reset mid-operation (SUM/CLAMP/EMIT): the in-flight packet is discarded and no draw_req is issued.

Optional Feature:
- Macro: CURSOR_FRAME_SYNC_EN.
- Defined:
  - The visible cursorX/cursorY load from the pending position only on a frame_start pulse.
  - This prevents mid-frame cursor tearing on the overlay.
- Undefined:
  - The visible position registers load from pending one cycle after CLAMP.
  - frame_start is ignored, but the port remains.

Decomposition:
- Shared package cursor_pkg:
  - COORD_W=11 and DELTA_W=9.
  - Enum state_t {IDLE, SUM, CLAMP, EMIT}.
  - Default screen constants SCREEN_W=640 and SCREEN_H=480.
- Sub-module cursor_axis_acc:
  - Parameterised by LIMIT and INVERT; instantiated once per axis.
  - Performs sign-extend, shift, add/subtract and clamp.
  - The FSM and handshake stay in the top module.

Test Plan:
- Reset, then release reset -> cursorX=320, cursorY=240, move_ready=1, draw_req=0.
- Packet dx=+10, dy=+5, btn=0 (sync disabled) -> cursor (330,235) 3 cycles after accept; no draw_req.
- From (320,240), dx=-256 twice -> X=64 after the first packet, X=0 after the second. dx=+255 repeated 3 times from 0 -> X=639, held.
- Packet dx=0, dy=0, btn=1 at (100,100) -> exactly one draw_req with draw_x=100, draw_y=100.
- Sync enabled, packet dx=+1 -> cursorX unchanged until frame_start, then 321. frame_start coincident with CLAMP -> update deferred to the next frame_start.
- Reset asserted during SUM with btn=1 -> no draw_req, position is (320,240), move_ready=1 on the next cycle.
